// File: rtl/saes_dec_stream_loader.sv
// Byte-stream loader/unloader around a combinational S-AES decryptor.
// Optional: SAES_KEY_LOCK_EN locks the key after the first load.
module saes_dec_stream_loader #(
  parameter int SETTLE_CYCLES = 1,
  parameter int COUNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         in_byte,
  input  logic               in_is_key,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [15:0]        Cipher_Text,
  output logic [15:0]        Key,
  input  logic [15:0]        Plain_Text,
  output logic [7:0]         out_byte,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               key_loaded,
  output logic               seq_err,
  output logic [COUNT_W-1:0] blk_count
);

  typedef enum logic [2:0] {
    IDLE,
    HI_HELD,
    SETTLE,
    OUT_HI,
    OUT_LO
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         held_q, held_d;
  logic               type_q, type_d;
  logic [15:0]        key_q, key_d;
  logic [15:0]        ct_q, ct_d;
  logic [7:0]         ob_q, ob_d;
  logic [7:0]         lo_q, lo_d;
  logic               ov_q, ov_d;
  logic               kl_q, kl_d;
  logic               se_q, se_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [COUNT_W-1:0] blk_q, blk_d;

  logic in_fire;
  logic out_fire;

  assign in_ready    = (state_q == IDLE) || (state_q == HI_HELD);
  assign in_fire     = in_valid && in_ready;
  assign out_fire    = ov_q && out_ready;
  assign Cipher_Text = ct_q;
  assign Key         = key_q;
  assign out_byte    = ob_q;
  assign out_valid   = ov_q;
  assign key_loaded  = kl_q;
  assign seq_err     = se_q;
  assign blk_count   = blk_q;

  // next-state and datapath updates
  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    type_d  = type_q;
    key_d   = key_q;
    ct_d    = ct_q;
    ob_d    = ob_q;
    lo_d    = lo_q;
    ov_d    = ov_q;
    kl_d    = kl_q;
    se_d    = 1'b0;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          held_d  = in_byte;
          type_d  = in_is_key;
          state_d = HI_HELD;
        end
      end
      HI_HELD: begin
        if (in_fire) begin
          if (in_is_key != type_q) begin
            se_d   = 1'b1;
            held_d = in_byte;
            type_d = in_is_key;
          end else if (type_q) begin
`ifdef SAES_KEY_LOCK_EN
            if (kl_q) begin
              se_d = 1'b1;
            end else begin
              key_d = {held_q, in_byte};
              kl_d  = 1'b1;
            end
`else
            key_d = {held_q, in_byte};
            kl_d  = 1'b1;
`endif
            state_d = IDLE;
          end else if (kl_q) begin
            ct_d    = {held_q, in_byte};
            cnt_d   = 4'(SETTLE_CYCLES);
            state_d = SETTLE;
          end else begin
            se_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          ob_d    = Plain_Text[15:8];
          lo_d    = Plain_Text[7:0];
          ov_d    = 1'b1;
          state_d = OUT_HI;
        end
      end
      OUT_HI: begin
        if (out_fire) begin
          ob_d    = lo_q;
          state_d = OUT_LO;
        end
      end
      OUT_LO: begin
        if (out_fire) begin
          ov_d    = 1'b0;
          blk_d   = blk_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      held_q  <= '0;
      type_q  <= 1'b0;
      key_q   <= '0;
      ct_q    <= '0;
      ob_q    <= '0;
      lo_q    <= '0;
      ov_q    <= 1'b0;
      kl_q    <= 1'b0;
      se_q    <= 1'b0;
      cnt_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
      type_q  <= type_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      ob_q    <= ob_d;
      lo_q    <= lo_d;
      ov_q    <= ov_d;
      kl_q    <= kl_d;
      se_q    <= se_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
    end
  end

endmodule

// File: tb/tb_saes_dec_stream_loader.sv
// Directed bench for saes_dec_stream_loader (SETTLE_CYCLES=4).
// Decryptor core stubbed: 0x4AF5/0x24EC -> 0xD728, else CT^Key.
module tb_saes_dec_stream_loader;

  logic        clk = 0;
  logic        rst_n = 0;
  logic [7:0]  in_byte = 0;
  logic        in_is_key = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] Cipher_Text;
  logic [15:0] Key;
  logic [15:0] Plain_Text;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 0;
  logic        key_loaded;
  logic        seq_err;
  logic [15:0] blk_count;

  int total = 0;
  int bad = 0;
  int seq_n = 0;
  logic [7:0] outq[$];

  saes_dec_stream_loader #(.SETTLE_CYCLES(4), .COUNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_byte(in_byte), .in_is_key(in_is_key),
    .in_valid(in_valid), .in_ready(in_ready),
    .Cipher_Text(Cipher_Text), .Key(Key),
    .Plain_Text(Plain_Text),
    .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready),
    .key_loaded(key_loaded), .seq_err(seq_err),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  assign Plain_Text =
    (Key == 16'h4AF5 && Cipher_Text == 16'h24EC) ?
    16'hD728 : (Cipher_Text ^ Key);

  always @(negedge clk)
    if (seq_err === 1'b1) seq_n++;

  always @(posedge clk)
    if (rst_n && out_valid && out_ready) outq.push_back(out_byte);

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // called at posedge+1; returns at posedge+1 after the handshake
  task automatic send(input logic [7:0] b, input logic k);
    int n;
    n = 0;
    in_byte = b;
    in_is_key = k;
    in_valid = 1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_blk(input string tag, input logic [15:0] n);
    int c;
    c = 0;
    while (blk_count !== n && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check(tag, blk_count, n);
  endtask

  task automatic check_out(input string tag,
                           input logic [15:0] exp);
    check({tag, "_n"}, outq.size(), 2);
    if (outq.size() == 2)
      check(tag, {outq[0], outq[1]}, exp);
    outq.delete();
  endtask

  initial begin
    int errs;
    logic [15:0] exp_key;
    logic [15:0] exp_pt;
    int exp_seq;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ct", Cipher_Text, 0);
    check("rst_key", Key, 0);
    check("rst_ob", out_byte, 0);
    check("rst_ov", out_valid, 0);
    check("rst_kl", key_loaded, 0);
    check("rst_se", seq_err, 0);
    check("rst_blk", blk_count, 0);
    rst_n = 1;
    @(posedge clk); #1;
    check("rst_rdy", in_ready, 1);

    // cipher with no key loaded
    out_ready = 1;
    send(8'h24, 0);
    send(8'hEC, 0);
    repeat (8) @(posedge clk);
    #1;
    check("nokey_seq", seq_n, 1);
    check("nokey_ct", Cipher_Text, 0);
    check("nokey_blk", blk_count, 0);
    check("nokey_out", outq.size(), 0);
    check("nokey_rdy", in_ready, 1);

    // basic decrypt with latency check
    send(8'h4A, 1);
    send(8'hF5, 1);
    check("basic_key", Key, 16'h4AF5);
    check("basic_kl", key_loaded, 1);
    send(8'h24, 0);
    send(8'hEC, 0);
    check("basic_ct", Cipher_Text, 16'h24EC);
    check("basic_busy", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    check("lat_early", out_valid, 0);
    @(posedge clk); #1;
    check("lat_ov", out_valid, 1);
    check("lat_ob", out_byte, 8'hD7);
    wait_blk("basic_blk", 1);
    check_out("basic_out", 16'hD728);
    check("basic_seq", seq_n, 1);

    // back-pressure
    out_ready = 0;
    send(8'h24, 0);
    send(8'hEC, 0);
    repeat (4) @(posedge clk);
    #1;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_byte !== 8'hD7 || out_valid !== 1'b1 ||
          in_ready !== 1'b0)
        errs++;
      @(posedge clk); #1;
    end
    check("bp_hold", errs, 0);
    check("bp_none", outq.size(), 0);
    out_ready = 1;
    wait_blk("bp_blk", 2);
    check_out("bp_out", 16'hD728);

    // type switch inside a word
    send(8'h4A, 1);
    send(8'h24, 0);
    @(posedge clk); #1;
    check("sw_seq", seq_n, 2);
    send(8'hEC, 0);
    check("sw_ct", Cipher_Text, 16'h24EC);
    check("sw_key", Key, 16'h4AF5);
    wait_blk("sw_blk", 3);
    check_out("sw_out", 16'hD728);

    // second key word: accepted, or rejected when locked
`ifdef SAES_KEY_LOCK_EN
    exp_key = 16'h4AF5;
    exp_pt  = 16'hD728;
    exp_seq = 3;
`else
    exp_key = 16'h1234;
    exp_pt  = 16'h36D8;
    exp_seq = 2;
`endif
    send(8'h12, 1);
    send(8'h34, 1);
    @(posedge clk); #1;
    check("k2_key", Key, exp_key);
    check("k2_seq", seq_n, exp_seq);
    send(8'h24, 0);
    send(8'hEC, 0);
    wait_blk("k2_blk", 4);
    check_out("k2_out", exp_pt);

    // reset in the middle of SETTLE
    send(8'h24, 0);
    send(8'hEC, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    check("mr_ct", Cipher_Text, 0);
    check("mr_key", Key, 0);
    check("mr_ov", out_valid, 0);
    check("mr_kl", key_loaded, 0);
    check("mr_blk", blk_count, 0);
    check("mr_rdy", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    check("mr_none", outq.size(), 0);
    check("mr_ov2", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/saes_dec_stream_loader.md
Name: saes_dec_stream_loader

Overview:
- Byte-stream front/back end for the combinational simplified-AES decryptor core.
- Assembles 16-bit key and cipher words from an 8-bit valid/ready input stream and drives the core's Cipher_Text/Key inputs from registers.
- After a programmable settle time, captures the core's Plain_Text and returns it as two bytes on an 8-bit valid/ready output stream.
- One block in flight at a time.

Parameters:
- SETTLE_CYCLES, 1, clock edges between loading Cipher_Text and sampling Plain_Text; legal range 1..15.
- COUNT_W, 16, width of the decrypted-block counter.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_byte  input  8  incoming key or cipher byte, high byte first
- in_is_key  input  1  qualifies in_byte as key byte (1) or cipher byte (0)
- in_valid  input  1  in_byte valid
- in_ready  output  1  loader can accept in_byte
- Cipher_Text  output  16  registered cipher word to the decryptor core
- Key  output  16  registered key to the decryptor core
- Plain_Text  input  16  plaintext returned by the decryptor core
- out_byte  output  8  plaintext byte, high byte first
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer accepts out_byte
- key_loaded  output  1  a complete 16-bit key has been loaded since reset
- seq_err  output  1  one-cycle pulse on a byte-sequence violation
- blk_count  output  COUNT_W  number of plaintext blocks fully delivered

Behaviour:
- Reset values: Cipher_Text=0, Key=0, out_byte=0, out_valid=0, key_loaded=0, seq_err=0, blk_count=0, state=IDLE. in_ready is combinational and reads 1 after reset.
- Handshake rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_byte and out_valid hold stable until transferred.
- FSM states: IDLE, HI_HELD, SETTLE, OUT_HI, OUT_LO.
- IDLE (in_ready=1):
  - A transfer stores in_byte into a high-byte holding register, latches in_is_key as the word type, then goes to HI_HELD.
- HI_HELD (in_ready=1):
  - Transfer whose in_is_key matches the latched type:
    - Key type: Key <= {held, in_byte}; key_loaded <= 1; go to IDLE.
    - Cipher type with key_loaded=1: Cipher_Text <= {held, in_byte}; load settle counter with SETTLE_CYCLES; go to SETTLE.
    - Cipher type with key_loaded=0: word discarded; seq_err pulses; go to IDLE.
  - Transfer whose in_is_key differs from the latched type: held byte discarded; seq_err pulses; the new byte becomes the held high byte with its own type; stay in HI_HELD.
- SETTLE (in_ready=0):
  - Counter decrements each edge.
  - On the edge where it reaches 0: out_byte <= Plain_Text[15:8], an internal low register <= Plain_Text[7:0], out_valid <= 1, go to OUT_HI.
- OUT_HI (in_ready=0): on output transfer, out_byte <= low register, go to OUT_LO.
- OUT_LO (in_ready=0): on output transfer, out_valid <= 0, blk_count increments (wraps modulo 2^COUNT_W), go to IDLE.
- Latency with SETTLE_CYCLES=1: low cipher byte accepted at edge E0; Plain_Text sampled at E1; out_valid=1 in the cycle after E1. In general, first output byte is valid SETTLE_CYCLES cycles after the low-byte handshake edge.
- Back-pressure: out_ready may stay low indefinitely; no data loss; in_ready stays 0.
- Key update between blocks is allowed. A key word received in IDLE/HI_HELD affects only later blocks, because Key is never written outside IDLE/HI_HELD.
- seq_err is a single-cycle pulse asserted on the edge after the violating transfer; it has no other side effect.
- Reset asserted mid-operation (any state) immediately returns all registers to reset values. A partially assembled word and an undelivered plaintext are dropped; the key must be reloaded.

Optional Feature:
- Macro SAES_KEY_LOCK_EN.
- Defined: once key_loaded=1, any later key word is rejected. Key is unchanged, seq_err pulses when the low key byte transfers, and the FSM returns to IDLE. Only rst_n unlocks the key.
- Undefined: key words are accepted at any time in IDLE/HI_HELD, as described in Behaviour.

Test Plan:
- Basic decrypt: key bytes 0x4A,0xF5 (in_is_key=1), then cipher bytes 0x24,0xEC, out_ready=1 -> Key=0x4AF5, Cipher_Text=0x24EC, out bytes 0xD7 then 0x28, blk_count=1, seq_err never pulses.
- No key: cipher bytes 0x24,0xEC sent after reset -> seq_err pulses once, no out_valid, blk_count=0, Cipher_Text stays 0.
- Back-pressure: repeat the basic case with out_ready=0 for 20 cycles -> out_byte holds 0xD7, out_valid=1, in_ready=0 throughout; after release, 0xD7 then 0x28 are delivered.
- Type switch: key byte 0x4A, then cipher byte 0x24 -> seq_err pulse, state HI_HELD with 0x24 held; then 0xEC -> cipher word 0x24EC is used only if a key is already loaded.
- Reset mid-SETTLE with SETTLE_CYCLES=4: assert rst_n=0 two cycles after the low cipher byte -> all outputs return to reset values immediately, no output byte emitted.
- SAES_KEY_LOCK_EN: load key 0x4AF5, then key 0x1234 -> Key stays 0x4AF5, seq_err pulses; next cipher 0x24EC still decrypts to 0xD728.
